// File: rtl/mio_bus_arbiter_if.sv
// mio_bus_arbiter_if -- requester-side and MIO-side signals of the bus arbiter.
//   slave  : view taken by the arbiter
//   master : view taken by the requesters and the MIO bus model around it
interface mio_bus_arbiter_if #(
  parameter int N_M = 2,
  parameter int AW  = 32
);
  logic [N_M-1:0]    m_req;
  logic [N_M-1:0]    m_we;
  logic [N_M-1:0]    m_sgn;
  logic [2*N_M-1:0]  m_size;
  logic [AW*N_M-1:0] m_addr;
  logic [32*N_M-1:0] m_wdata;
  logic [N_M-1:0]    m_ack;
  logic              m_err;
  logic [31:0]       m_rdata;
  logic              breq_o;
  logic              mem_w;
  logic [AW-1:0]     Addr_out;
  logic [31:0]       data_out;
  logic [3:0]        byte_en;
  logic [31:0]       data_in;
  logic              MIO_ready;
  logic [2:0]        grant;

  modport slave (
    input  m_req, m_we, m_sgn, m_size, m_addr, m_wdata, data_in, MIO_ready,
    output m_ack, m_err, m_rdata, breq_o, mem_w, Addr_out, data_out, byte_en, grant
  );

  modport master (
    output m_req, m_we, m_sgn, m_size, m_addr, m_wdata, data_in, MIO_ready,
    input  m_ack, m_err, m_rdata, breq_o, mem_w, Addr_out, data_out, byte_en, grant
  );
endinterface

// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter -- round-robin front-end from N_M requesters onto the MIO bus.
// Byte/half/word lanes, sign/zero-extended reads, misalignment errors.
// Optional macro MIO_TIMEOUT_EN: when defined, a bus cycle that sees no
// MIO_ready for TIMEOUT+1 cycles is ended with m_err; when undefined the
// bus cycle waits for MIO_ready indefinitely and TIMEOUT is unused.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access in flight; pick a round-robin winner
// ST_BUS  | breq_o high, waiting for MIO_ready (or timeout)
// ST_RESP | one-cycle m_ack to the granted requester
module mio_bus_arbiter #(
  parameter int N_M     = 2,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  mio_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

  state_t r_state, w_state_nxt;

  logic [N_M-1:0] r_ack, w_ack_nxt;
  logic           r_err, w_err_nxt;
  logic [31:0]    r_rdata, w_rdata_nxt;
  logic           r_breq, w_breq_nxt;
  logic           r_mem_w, w_mem_w_nxt;
  logic [AW-1:0]  r_addr_out, w_addr_out_nxt;
  logic [31:0]    r_data_out, w_data_out_nxt;
  logic [3:0]     r_be, w_be_nxt;
  logic [2:0]     r_grant, w_grant_nxt;
  logic           r_we, w_we_nxt;
  logic           r_sgn, w_sgn_nxt;
  logic [1:0]     r_size, w_size_nxt;
  logic [1:0]     r_addr_lo, w_addr_lo_nxt;

`ifdef MIO_TIMEOUT_EN
  logic [15:0]    r_tmr, w_tmr_nxt;
`else
  logic           w_unused_timeout;
  assign w_unused_timeout = |16'(TIMEOUT);
`endif

  // Requester fields spread into fixed 8-entry tables so a 3-bit index works for any N_M
  logic [7:0]    w_req8, w_we8, w_sgn8;
  logic [1:0]    w_size_a  [8];
  logic [AW-1:0] w_addr_a  [8];
  logic [31:0]   w_wdata_a [8];

  // Unpack the flat per-requester buses
  always_comb begin
    w_req8 = '0;
    w_we8  = '0;
    w_sgn8 = '0;
    for (int i = 0; i < 8; i++) begin
      w_size_a[i]  = '0;
      w_addr_a[i]  = '0;
      w_wdata_a[i] = '0;
    end
    for (int i = 0; i < N_M; i++) begin
      w_req8[i]    = bus.m_req[i];
      w_we8[i]     = bus.m_we[i];
      w_sgn8[i]    = bus.m_sgn[i];
      w_size_a[i]  = bus.m_size[2*i +: 2];
      w_addr_a[i]  = bus.m_addr[AW*i +: AW];
      w_wdata_a[i] = bus.m_wdata[32*i +: 32];
    end
  end

  logic       w_any;
  logic [2:0] w_win;

  // Round-robin search starting one past the last grant, wrapping at N_M
  always_comb begin
    logic [3:0] idx;
    w_any = 1'b0;
    w_win = r_grant;
    idx   = '0;
    for (int i = 1; i <= N_M; i++) begin
      idx = {1'b0, r_grant} + 4'(i);
      if (idx >= 4'(N_M)) idx = idx - 4'(N_M);
      if (!w_any && w_req8[idx[2:0]]) begin
        w_any = 1'b1;
        w_win = idx[2:0];
      end
    end
  end

  logic [1:0]    w_win_size;
  logic [AW-1:0] w_win_addr;
  logic [31:0]   w_win_wdata;
  logic          w_win_mis;
  logic [3:0]    w_win_be;
  logic [31:0]   w_win_wd;

  assign w_win_size  = w_size_a[w_win];
  assign w_win_addr  = w_addr_a[w_win];
  assign w_win_wdata = w_wdata_a[w_win];

  // Lane enables, replicated write data and alignment check for the winner; size 3 acts as word
  always_comb begin
    w_win_mis = 1'b0;
    w_win_be  = 4'hF;
    w_win_wd  = w_win_wdata;
    case (w_win_size)
      2'd0: begin
        w_win_be = 4'b0001 << w_win_addr[1:0];
        w_win_wd = {4{w_win_wdata[7:0]}};
      end
      2'd1: begin
        w_win_mis = w_win_addr[0];
        w_win_be  = 4'b0011 << w_win_addr[1:0];
        w_win_wd  = {2{w_win_wdata[15:0]}};
      end
      default: begin
        w_win_mis = |w_win_addr[1:0];
      end
    endcase
  end

  logic [31:0] w_rd_shift, w_rd_ext;
  assign w_rd_shift = bus.data_in >> {r_addr_lo, 3'b000};

  // Pick the addressed lane out of the bus word and extend it
  always_comb begin
    case (r_size)
      2'd0:    w_rd_ext = r_sgn ? {{24{w_rd_shift[7]}}, w_rd_shift[7:0]}
                                : {24'h0, w_rd_shift[7:0]};
      2'd1:    w_rd_ext = r_sgn ? {{16{w_rd_shift[15]}}, w_rd_shift[15:0]}
                                : {16'h0, w_rd_shift[15:0]};
      default: w_rd_ext = bus.data_in;
    endcase
  end

  logic [7:0] w_ack_win8, w_ack_gnt8;
  assign w_ack_win8 = 8'd1 << w_win;
  assign w_ack_gnt8 = 8'd1 << r_grant;

  // Next state and next values of every registered output
  always_comb begin
    w_state_nxt    = r_state;
    w_ack_nxt      = '0;
    w_err_nxt      = 1'b0;
    w_rdata_nxt    = '0;
    w_breq_nxt     = r_breq;
    w_mem_w_nxt    = r_mem_w;
    w_addr_out_nxt = r_addr_out;
    w_data_out_nxt = r_data_out;
    w_be_nxt       = r_be;
    w_grant_nxt    = r_grant;
    w_we_nxt       = r_we;
    w_sgn_nxt      = r_sgn;
    w_size_nxt     = r_size;
    w_addr_lo_nxt  = r_addr_lo;
`ifdef MIO_TIMEOUT_EN
    w_tmr_nxt      = r_tmr;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant_nxt   = w_win;
          w_we_nxt      = w_we8[w_win];
          w_sgn_nxt     = w_sgn8[w_win];
          w_size_nxt    = w_win_size;
          w_addr_lo_nxt = w_win_addr[1:0];
          if (w_win_mis) begin
            w_state_nxt = ST_RESP;
            w_ack_nxt   = w_ack_win8[N_M-1:0];
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt    = ST_BUS;
            w_breq_nxt     = 1'b1;
            w_mem_w_nxt    = w_we8[w_win];
            w_addr_out_nxt = {w_win_addr[AW-1:2], 2'b00};
            w_be_nxt       = w_win_be;
            w_data_out_nxt = w_we8[w_win] ? w_win_wd : 32'h0;
`ifdef MIO_TIMEOUT_EN
            w_tmr_nxt      = 16'(TIMEOUT);
`endif
          end
        end
      end
      ST_BUS: begin
        if (bus.MIO_ready) begin
          w_state_nxt = ST_RESP;
          w_breq_nxt  = 1'b0;
          w_mem_w_nxt = 1'b0;
          w_ack_nxt   = w_ack_gnt8[N_M-1:0];
          w_rdata_nxt = r_we ? 32'h0 : w_rd_ext;
        end
`ifdef MIO_TIMEOUT_EN
        else if (r_tmr == 16'd0) begin
          w_state_nxt = ST_RESP;
          w_breq_nxt  = 1'b0;
          w_mem_w_nxt = 1'b0;
          w_ack_nxt   = w_ack_gnt8[N_M-1:0];
          w_err_nxt   = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr - 16'd1;
        end
`endif
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Output and captured-field registers; grant pointer resets so requester 0 wins first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack      <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_breq     <= 1'b0;
      r_mem_w    <= 1'b0;
      r_addr_out <= '0;
      r_data_out <= '0;
      r_be       <= '0;
      r_grant    <= 3'(N_M-1);
      r_we       <= 1'b0;
      r_sgn      <= 1'b0;
      r_size     <= '0;
      r_addr_lo  <= '0;
`ifdef MIO_TIMEOUT_EN
      r_tmr      <= '0;
`endif
    end else begin
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_rdata    <= w_rdata_nxt;
      r_breq     <= w_breq_nxt;
      r_mem_w    <= w_mem_w_nxt;
      r_addr_out <= w_addr_out_nxt;
      r_data_out <= w_data_out_nxt;
      r_be       <= w_be_nxt;
      r_grant    <= w_grant_nxt;
      r_we       <= w_we_nxt;
      r_sgn      <= w_sgn_nxt;
      r_size     <= w_size_nxt;
      r_addr_lo  <= w_addr_lo_nxt;
`ifdef MIO_TIMEOUT_EN
      r_tmr      <= w_tmr_nxt;
`endif
    end
  end

  assign bus.m_ack    = r_ack;
  assign bus.m_err    = r_err;
  assign bus.m_rdata  = r_rdata;
  assign bus.breq_o   = r_breq;
  assign bus.mem_w    = r_mem_w;
  assign bus.Addr_out = r_addr_out;
  assign bus.data_out = r_data_out;
  assign bus.byte_en  = r_be;
  assign bus.grant    = r_grant;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb_mio_bus_arbiter -- directed bench for mio_bus_arbiter with three requesters.
module tb_mio_bus_arbiter;
  localparam int N_M     = 3;
  localparam int AW      = 32;
  localparam int TIMEOUT = 4;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  mio_bus_arbiter_if #(.N_M(N_M), .AW(AW)) bus_if ();

  mio_bus_arbiter #(.N_M(N_M), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    bus_if.m_req     = '0;
    bus_if.m_we      = '0;
    bus_if.m_sgn     = '0;
    bus_if.m_size    = '0;
    bus_if.m_addr    = '0;
    bus_if.m_wdata   = '0;
    bus_if.data_in   = '0;
    bus_if.MIO_ready = 1'b0;
  endtask

  task automatic set_req(input int idx, input bit we, input bit sgn, input bit [1:0] size,
                         input bit [31:0] addr, input bit [31:0] wdata);
    bus_if.m_req[idx]           = 1'b1;
    bus_if.m_we[idx]            = we;
    bus_if.m_sgn[idx]           = sgn;
    bus_if.m_size[idx*2 +: 2]   = size;
    bus_if.m_addr[idx*32 +: 32] = addr;
    bus_if.m_wdata[idx*32 +: 32] = wdata;
  endtask

  task automatic test_reset();
    clear_all();
    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    tick();
    n_total++; if (bus_if.breq_o !== 1'b0) $display("FAIL rst_breq: got %b want 0", bus_if.breq_o); else n_pass++;
    n_total++; if (bus_if.mem_w !== 1'b0) $display("FAIL rst_mem_w: got %b want 0", bus_if.mem_w); else n_pass++;
    n_total++; if (bus_if.m_ack !== 3'b000) $display("FAIL rst_ack: got %b want 000", bus_if.m_ack); else n_pass++;
    n_total++; if (bus_if.m_err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus_if.m_err); else n_pass++;
    n_total++; if (bus_if.m_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", bus_if.m_rdata); else n_pass++;
    n_total++; if (bus_if.Addr_out !== 32'h0) $display("FAIL rst_addr: got %h want 0", bus_if.Addr_out); else n_pass++;
    n_total++; if (bus_if.data_out !== 32'h0) $display("FAIL rst_dout: got %h want 0", bus_if.data_out); else n_pass++;
    n_total++; if (bus_if.byte_en !== 4'h0) $display("FAIL rst_be: got %h want 0", bus_if.byte_en); else n_pass++;
    n_total++; if (bus_if.grant !== 3'd2) $display("FAIL rst_grant: got %0d want 2", bus_if.grant); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_read_word();
    set_req(0, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
    tick();
    n_total++; if (bus_if.breq_o !== 1'b1) $display("FAIL rd_breq: got %b want 1", bus_if.breq_o); else n_pass++;
    n_total++; if (bus_if.Addr_out !== 32'h100) $display("FAIL rd_addr: got %h want 100", bus_if.Addr_out); else n_pass++;
    n_total++; if (bus_if.byte_en !== 4'hF) $display("FAIL rd_be: got %h want f", bus_if.byte_en); else n_pass++;
    n_total++; if (bus_if.mem_w !== 1'b0) $display("FAIL rd_mem_w: got %b want 0", bus_if.mem_w); else n_pass++;
    n_total++; if (bus_if.grant !== 3'd0) $display("FAIL rd_grant: got %0d want 0", bus_if.grant); else n_pass++;
    repeat (3) tick();
    n_total++; if (bus_if.breq_o !== 1'b1 || bus_if.m_ack !== 3'b000) $display("FAIL rd_wait: got breq %b ack %b want breq 1 ack 000", bus_if.breq_o, bus_if.m_ack); else n_pass++;
    bus_if.MIO_ready = 1'b1;
    bus_if.data_in   = 32'hDEADBEEF;
    tick();
    n_total++; if (bus_if.m_ack !== 3'b001) $display("FAIL rd_ack: got %b want 001", bus_if.m_ack); else n_pass++;
    n_total++; if (bus_if.m_err !== 1'b0) $display("FAIL rd_err: got %b want 0", bus_if.m_err); else n_pass++;
    n_total++; if (bus_if.m_rdata !== 32'hDEADBEEF) $display("FAIL rd_rdata: got %h want deadbeef", bus_if.m_rdata); else n_pass++;
    n_total++; if (bus_if.breq_o !== 1'b0) $display("FAIL rd_breq_drop: got %b want 0", bus_if.breq_o); else n_pass++;
    clear_all();
    tick();
    n_total++; if (bus_if.m_ack !== 3'b000) $display("FAIL rd_ack_once: got %b want 000", bus_if.m_ack); else n_pass++;
  endtask

  task automatic test_byte_store();
    set_req(1, 1'b1, 1'b0, 2'd0, 32'h103, 32'h0000005A);
    tick();
    n_total++; if (bus_if.mem_w !== 1'b1) $display("FAIL st_mem_w: got %b want 1", bus_if.mem_w); else n_pass++;
    n_total++; if (bus_if.byte_en !== 4'b1000) $display("FAIL st_be: got %b want 1000", bus_if.byte_en); else n_pass++;
    n_total++; if (bus_if.data_out !== 32'h5A5A5A5A) $display("FAIL st_dout: got %h want 5a5a5a5a", bus_if.data_out); else n_pass++;
    n_total++; if (bus_if.Addr_out !== 32'h100) $display("FAIL st_addr: got %h want 100", bus_if.Addr_out); else n_pass++;
    n_total++; if (bus_if.grant !== 3'd1) $display("FAIL st_grant: got %0d want 1", bus_if.grant); else n_pass++;
    bus_if.MIO_ready = 1'b1;
    bus_if.data_in   = 32'hFFFFFFFF;
    tick();
    n_total++; if (bus_if.m_ack !== 3'b010) $display("FAIL st_ack: got %b want 010", bus_if.m_ack); else n_pass++;
    n_total++; if (bus_if.m_rdata !== 32'h0) $display("FAIL st_rdata: got %h want 0", bus_if.m_rdata); else n_pass++;
    n_total++; if (bus_if.mem_w !== 1'b0) $display("FAIL st_mem_w_drop: got %b want 0", bus_if.mem_w); else n_pass++;
    clear_all();
    tick();
  endtask

  task automatic test_loads();
    int          idx  [5];
    bit          sgn  [5];
    bit [1:0]    size [5];
    bit [31:0]   addr [5];
    bit [31:0]   din  [5];
    bit [3:0]    be   [5];
    bit [31:0]   rd   [5];
    idx[0] = 2; sgn[0] = 1; size[0] = 2'd0; addr[0] = 32'h102; din[0] = 32'h00800000; be[0] = 4'b0100; rd[0] = 32'hFFFFFF80;
    idx[1] = 0; sgn[1] = 0; size[1] = 2'd1; addr[1] = 32'h102; din[1] = 32'h80010000; be[1] = 4'b1100; rd[1] = 32'h00008001;
    idx[2] = 1; sgn[2] = 1; size[2] = 2'd1; addr[2] = 32'h100; din[2] = 32'h1234F00D; be[2] = 4'b0011; rd[2] = 32'hFFFFF00D;
    idx[3] = 2; sgn[3] = 0; size[3] = 2'd0; addr[3] = 32'h101; din[3] = 32'h0000A500; be[3] = 4'b0010; rd[3] = 32'h000000A5;
    idx[4] = 0; sgn[4] = 1; size[4] = 2'd3; addr[4] = 32'h204; din[4] = 32'h87654321; be[4] = 4'b1111; rd[4] = 32'h87654321;
    for (int k = 0; k < 5; k++) begin
      set_req(idx[k], 1'b0, sgn[k], size[k], addr[k], 32'h0);
      tick();
      n_total++; if (bus_if.byte_en !== be[k] || bus_if.grant !== 3'(idx[k])) $display("FAIL ld%0d_be_grant: got be %b grant %0d want be %b grant %0d", k, bus_if.byte_en, bus_if.grant, be[k], idx[k]); else n_pass++;
      bus_if.MIO_ready = 1'b1;
      bus_if.data_in   = din[k];
      tick();
      n_total++; if (bus_if.m_rdata !== rd[k]) $display("FAIL ld%0d_rdata: got %h want %h", k, bus_if.m_rdata, rd[k]); else n_pass++;
      clear_all();
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int unsigned exp_order [4];
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 2'd2, 32'h10, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'd2, 32'h20, 32'h0);
    set_req(2, 1'b0, 1'b0, 2'd2, 32'h30, 32'h0);
    bus_if.MIO_ready = 1'b1;
    bus_if.data_in   = 32'h11111111;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_total++; if (bus_if.grant !== 3'(exp_order[k]) || bus_if.breq_o !== 1'b1) $display("FAIL b2b%0d_grant: got grant %0d breq %b want grant %0d breq 1", k, bus_if.grant, bus_if.breq_o, exp_order[k]); else n_pass++;
      tick();
      n_total++; if (bus_if.m_ack !== 3'(1 << exp_order[k]) || bus_if.m_rdata !== 32'h11111111) $display("FAIL b2b%0d_ack: got ack %b rdata %h want ack %b rdata 11111111", k, bus_if.m_ack, bus_if.m_rdata, 3'(1 << exp_order[k])); else n_pass++;
      tick();
      n_total++; if (bus_if.m_ack !== 3'b000 || bus_if.breq_o !== 1'b0) $display("FAIL b2b%0d_gap: got ack %b breq %b want ack 000 breq 0", k, bus_if.m_ack, bus_if.breq_o); else n_pass++;
    end
    clear_all();
    tick();
  endtask

  task automatic test_misaligned();
    bus_if.MIO_ready = 1'b1;
    set_req(1, 1'b0, 1'b0, 2'd2, 32'h102, 32'h0);
    tick();
    n_total++; if (bus_if.breq_o !== 1'b0) $display("FAIL mis_w_breq: got %b want 0", bus_if.breq_o); else n_pass++;
    n_total++; if (bus_if.m_ack !== 3'b010 || bus_if.m_err !== 1'b1) $display("FAIL mis_w_ack: got ack %b err %b want ack 010 err 1", bus_if.m_ack, bus_if.m_err); else n_pass++;
    n_total++; if (bus_if.m_rdata !== 32'h0) $display("FAIL mis_w_rdata: got %h want 0", bus_if.m_rdata); else n_pass++;
    bus_if.m_req = '0;
    tick();
    n_total++; if (bus_if.m_ack !== 3'b000 || bus_if.m_err !== 1'b0 || bus_if.breq_o !== 1'b0) $display("FAIL mis_idle: got ack %b err %b breq %b want 000 0 0", bus_if.m_ack, bus_if.m_err, bus_if.breq_o); else n_pass++;
    set_req(2, 1'b1, 1'b0, 2'd1, 32'h101, 32'h1234);
    tick();
    n_total++; if (bus_if.m_ack !== 3'b100 || bus_if.m_err !== 1'b1 || bus_if.breq_o !== 1'b0 || bus_if.mem_w !== 1'b0) $display("FAIL mis_h: got ack %b err %b breq %b memw %b want 100 1 0 0", bus_if.m_ack, bus_if.m_err, bus_if.breq_o, bus_if.mem_w); else n_pass++;
    clear_all();
    tick();
  endtask

  task automatic test_timeout();
`ifdef MIO_TIMEOUT_EN
    bus_if.data_in = 32'h00000055;
    set_req(0, 1'b0, 1'b0, 2'd2, 32'h200, 32'h0);
    tick();
    n_total++; if (bus_if.breq_o !== 1'b1) $display("FAIL to_breq_start: got %b want 1", bus_if.breq_o); else n_pass++;
    repeat (4) tick();
    n_total++; if (bus_if.breq_o !== 1'b1 || bus_if.m_ack !== 3'b000) $display("FAIL to_breq_hold: got breq %b ack %b want 1 000", bus_if.breq_o, bus_if.m_ack); else n_pass++;
    tick();
    n_total++; if (bus_if.breq_o !== 1'b0 || bus_if.m_ack !== 3'b001 || bus_if.m_err !== 1'b1) $display("FAIL to_fire: got breq %b ack %b err %b want 0 001 1", bus_if.breq_o, bus_if.m_ack, bus_if.m_err); else n_pass++;
    n_total++; if (bus_if.m_rdata !== 32'h0) $display("FAIL to_rdata: got %h want 0", bus_if.m_rdata); else n_pass++;
    clear_all();
    tick();
    bus_if.data_in = 32'h0BADF00D;
    set_req(0, 1'b0, 1'b0, 2'd2, 32'h200, 32'h0);
    tick();
    repeat (4) tick();
    bus_if.MIO_ready = 1'b1;
    tick();
    n_total++; if (bus_if.m_ack !== 3'b001 || bus_if.m_err !== 1'b0 || bus_if.m_rdata !== 32'h0BADF00D) $display("FAIL to_ready_wins: got ack %b err %b rdata %h want 001 0 0badf00d", bus_if.m_ack, bus_if.m_err, bus_if.m_rdata); else n_pass++;
    clear_all();
    tick();
`else
    int high_cnt;
    int ack_cnt;
    high_cnt = 0;
    ack_cnt  = 0;
    set_req(0, 1'b0, 1'b0, 2'd2, 32'h200, 32'h0);
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus_if.breq_o === 1'b1) high_cnt++;
      if (bus_if.m_ack !== 3'b000) ack_cnt++;
    end
    n_total++; if (high_cnt !== 100) $display("FAIL nto_breq: got %0d cycles want 100", high_cnt); else n_pass++;
    n_total++; if (ack_cnt !== 0) $display("FAIL nto_ack: got %0d acks want 0", ack_cnt); else n_pass++;
    bus_if.MIO_ready = 1'b1;
    bus_if.data_in   = 32'h0BADF00D;
    tick();
    n_total++; if (bus_if.m_ack !== 3'b001 || bus_if.m_err !== 1'b0 || bus_if.m_rdata !== 32'h0BADF00D) $display("FAIL nto_done: got ack %b err %b rdata %h want 001 0 0badf00d", bus_if.m_ack, bus_if.m_err, bus_if.m_rdata); else n_pass++;
    clear_all();
    tick();
`endif
  endtask

  task automatic test_reset_mid_bus();
    set_req(1, 1'b1, 1'b0, 2'd2, 32'h300, 32'hCAFEF00D);
    tick();
    n_total++; if (bus_if.breq_o !== 1'b1 || bus_if.mem_w !== 1'b1 || bus_if.grant !== 3'd1) $display("FAIL rmb_start: got breq %b memw %b grant %0d want 1 1 1", bus_if.breq_o, bus_if.mem_w, bus_if.grant); else n_pass++;
    tick();
    reset = 1'b0;
    #1;
    n_total++; if (bus_if.breq_o !== 1'b0 || bus_if.mem_w !== 1'b0) $display("FAIL rmb_async: got breq %b memw %b want 0 0", bus_if.breq_o, bus_if.mem_w); else n_pass++;
    n_total++; if (bus_if.grant !== 3'd2 || bus_if.m_ack !== 3'b000) $display("FAIL rmb_state: got grant %0d ack %b want 2 000", bus_if.grant, bus_if.m_ack); else n_pass++;
    set_req(0, 1'b0, 1'b0, 2'd2, 32'h400, 32'h0);
    tick();
    n_total++; if (bus_if.m_ack !== 3'b000 || bus_if.breq_o !== 1'b0) $display("FAIL rmb_hold: got ack %b breq %b want 000 0", bus_if.m_ack, bus_if.breq_o); else n_pass++;
    reset = 1'b1;
    tick();
    n_total++; if (bus_if.grant !== 3'd0 || bus_if.breq_o !== 1'b1 || bus_if.Addr_out !== 32'h400 || bus_if.mem_w !== 1'b0) $display("FAIL rmb_first: got grant %0d breq %b addr %h memw %b want 0 1 400 0", bus_if.grant, bus_if.breq_o, bus_if.Addr_out, bus_if.mem_w); else n_pass++;
    bus_if.MIO_ready = 1'b1;
    bus_if.data_in   = 32'h12345678;
    tick();
    n_total++; if (bus_if.m_ack !== 3'b001 || bus_if.m_rdata !== 32'h12345678) $display("FAIL rmb_ack: got ack %b rdata %h want 001 12345678", bus_if.m_ack, bus_if.m_rdata); else n_pass++;
    clear_all();
    tick();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_read_word();
    test_byte_store();
    test_loads();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_reset_mid_bus();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
